rca_result_fifo: RTL

//  Registered capture stage placed directly downstream of the combinational

---
 rtl/rca_result_fifo.sv | 116 +++++++++++
 1 files changed

// File: rtl/rca_result_fifo.sv
// rtl/rca_result_fifo.sv - registered capture FIFO for ripple-carry adder results
//
// Purpose:
//   Samples each operand pair and WIDTH+1-bit adder sum under a valid/ready
//   handshake, buffers the sums in a DEPTH-entry FIFO and counts accepted
//   sums whose carry-out (MSB) is set, saturating at 2^CNT_W-1.
//
// Optional feature (macro RCA_RESULT_CHECK_EN):
//   When defined, each accepted sum is compared against a behavioural
//   reference adder built from the operands; any difference sets the sticky
//   o_mismatch flag until reset. When undefined, the operands are unused and
//   o_mismatch is tied to 0.
//
// Ports:
//   i_clk        clock, rising edge
//   i_rst        synchronous reset, active-high
//   i_valid      upstream operands and sum valid
//   o_ready      stage can accept (FIFO not full, not in reset)
//   i_add_term1  operand A
//   i_add_term2  operand B
//   i_result     adder sum for the operands (MSB is carry-out)
//   o_valid      head entry available
//   i_ready      downstream consumes the head entry
//   o_result     head entry sum (0 when empty)
//   o_level      occupancy, 0..DEPTH
//   o_carry_cnt  accepted sums with carry-out set, saturating
//   o_mismatch   sticky self-check error

module rca_result_fifo #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  logic [WIDTH-1:0]         i_add_term1,
  input  logic [WIDTH-1:0]         i_add_term2,
  input  logic [WIDTH:0]           i_result,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [WIDTH:0]           o_result,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic [CNT_W-1:0]         o_carry_cnt,
  output logic                     o_mismatch
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL = LW'(DEPTH);

  logic [WIDTH:0]   mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [LW-1:0]    level;
  logic [CNT_W-1:0] carry_cnt;
  logic             push;
  logic             pop;

  // Ready depends only on registered occupancy and reset, never on i_ready,
  // so a full FIFO refuses a push even when it is popped in the same cycle.
  assign o_ready = !i_rst && (level != FULL);
  assign o_valid = (level != '0);
  assign o_result = o_valid ? mem[rd_ptr] : '0;
  assign o_level = level;
  assign o_carry_cnt = carry_cnt;

  assign push = i_valid && o_ready;
  assign pop  = o_valid && i_ready;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      level     <= '0;
      carry_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
      if (push && i_result[WIDTH] && (carry_cnt != '1))
        carry_cnt <= carry_cnt + 1'b1;
    end
  end

  // Storage is not reset; entries are only visible once the level covers them.
  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr] <= i_result;
  end

`ifdef RCA_RESULT_CHECK_EN
  logic [WIDTH:0] ref_sum;
  logic           mismatch;

  assign ref_sum = {1'b0, i_add_term1} + {1'b0, i_add_term2};

  always_ff @(posedge i_clk) begin
    if (i_rst)
      mismatch <= 1'b0;
    else if (push && (ref_sum != i_result))
      mismatch <= 1'b1;
  end

  assign o_mismatch = mismatch;
`else
  logic unused_terms;
  assign unused_terms = ^{i_add_term1, i_add_term2};
  assign o_mismatch = 1'b0;
`endif

endmodule
